uart_rx_os: RTL

- 16x-oversampling UART receiver: 8N1 frames on `serial_in` become bytes on a valid/ready output port.
- Sits between the board RX pin and the CPU memory-mapped UART registers.
- Adds over a plain mid-bit sampler: majority-vote sampling, false-start rejection, and framing/overrun error reporting.

---
 rtl/uart_rx_os.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver.
// A synchronised RX line is sampled three times around mid-bit and majority-voted.
// Start bits that vote high are rejected as glitches.
// Completed bytes leave on a valid/ready port, with one-cycle framing-error and overrun pulses.
module uart_rx_os #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    // Clocks per oversample tick, rounded to nearest.
    localparam int TICK_DIV = (CLOCK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int MID      = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_VOTE_A  = SW'(MID - 1);
    localparam logic [SW-1:0] S_VOTE_B  = SW'(MID);
    localparam logic [SW-1:0] S_DECIDE  = SW'(MID + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Two-of-three majority used for the mid-bit vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchroniser and arming registers.
    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_prev;
    logic [1:0]    r_flush_cnt;
    logic          r_armed;

    // Bit-timing registers.
    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_s;

    // Frame-assembly registers.
    state_t        r_state;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_vote_a;
    logic          r_vote_b;

    logic          w_rx;
    logic          w_start;
    logic          w_tick;
    logic          w_s_last;
    logic          w_decide;
    logic          w_vote;

    assign w_rx     = r_sync2;
    assign w_start  = (r_state == ST_IDLE) && r_armed && r_rx_prev && !w_rx;
    assign w_tick   = (r_state != ST_IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_s_last = (r_s == S_LAST);
    assign w_decide = w_tick && (r_s == S_DECIDE);
    assign w_vote   = maj3(r_vote_a, r_vote_b, w_rx);

    // Synchronise the RX pin and arm start detection only after the line is seen idle-high.
    // The synchroniser resets to 1, so a line held low through reset release would
    // otherwise look like a 1->0 edge; the flush counter waits until real line
    // samples have reached r_sync2 before any high level may arm the detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_flush_cnt <= 2'd0;
            r_armed     <= 1'b0;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            if (r_flush_cnt != 2'd2) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else if (w_rx) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    // Oversample tick divider: idle in IDLE, so every frame starts from zero at the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Receive FSM with sample counter, voting, byte assembly and the output port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_s            <= '0;
            r_bit_idx      <= 3'd0;
            r_shift        <= 8'd0;
            r_vote_a       <= 1'b1;
            r_vote_b       <= 1'b1;
            data_out       <= 8'd0;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // A consumed byte frees the port; a byte delivered this same cycle overrides this below.
            if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end

            if (w_tick) begin
                r_s <= w_s_last ? '0 : (r_s + SW'(1));
            end

            if (w_tick && (r_s == S_VOTE_A)) begin
                r_vote_a <= w_rx;
            end
            if (w_tick && (r_s == S_VOTE_B)) begin
                r_vote_b <= w_rx;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_START;
                        r_s       <= '0;
                        r_bit_idx <= 3'd0;
                        busy      <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_decide && w_vote) begin
                        // Line recovered before mid-bit: treat as noise.
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_tick && w_s_last) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= 3'd0;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        r_shift[r_bit_idx] <= w_vote;
                    end
                    if (w_tick && w_s_last) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                ST_STOP: begin
                    // Leave at mid-stop-bit so a start edge right after the stop bit is caught.
                    if (w_decide) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        if (!w_vote) begin
                            framing_error <= 1'b1;
                        end else if (!data_out_valid || data_out_ready) begin
                            data_out       <= r_shift;
                            data_out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
